alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_op_decode.sv | 46 ++++
 rtl/alu_issue_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU function-select encodings and NZCV bit positions
// shared by the ALU issue path. ALU_ISSUE_MUL_EN adds the MUL decode field.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_ORR  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_EOR  = 4'd4,
    OP_LSL  = 4'd5,
    OP_LSR  = 4'd6,
    OP_ANDS = 4'd7,
    OP_ADDS = 4'd8,
    OP_SUBS = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

  // 11..15 are never legal
  localparam logic [3:0] OP_ILL_LO = 4'd11;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  // flag vector is {v,c,n,z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic [4:0] fs;
    logic       c0;
    logic       sets_flags;
`ifdef ALU_ISSUE_MUL_EN
    logic       is_mul;
`endif
    logic       illegal;
  } dec_t;

  function automatic logic is_sop(input logic [3:0] op);
    return (op == OP_ANDS) || (op == OP_ADDS) ||
           (op == OP_SUBS);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode to ALU fs/c0 and class bits.
// Op 10 decodes as MUL only when ALU_ISSUE_MUL_EN is defined.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  // pure table lookup; anything unmatched is illegal
  always_comb begin
    dec = '0;
    dec.sets_flags = is_sop(op);
    unique case (1'b1)
      (op == OP_AND) || (op == OP_ANDS):
        dec.fs = FS_AND;
      (op == OP_ORR):
        dec.fs = FS_ORR;
      (op == OP_ADD) || (op == OP_ADDS):
        dec.fs = FS_ADD;
      (op == OP_SUB) || (op == OP_SUBS): begin
        dec.fs = FS_SUB;
        dec.c0 = 1'b1;
      end
      (op == OP_EOR):
        dec.fs = FS_EOR;
      (op == OP_LSL):
        dec.fs = FS_LSL;
      (op == OP_LSR):
        dec.fs = FS_LSR;
`ifdef ALU_ISSUE_MUL_EN
      (op == OP_MUL):
        dec.is_mul = 1'b1;
`endif
      (op >= OP_ILL_LO): begin
        dec = '0;
        dec.illegal = 1'b1;
      end
      default: begin
        dec = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: one-in-flight sequencer in front of the 64-bit ALU.
// ALU_ISSUE_MUL_EN enables the iterative shift-add MUL on the ALU adder.
module alu_issue_ctrl
  import alu_pkg::*;
`ifdef ALU_ISSUE_MUL_EN
#(
  parameter bit MUL_EARLY_EXIT = 1'b1
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic [3:0]  flags,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [4:0]  alu_fs,
  output logic        alu_c0,
  input  logic [63:0] alu_out,
  input  logic [3:0]  alu_status
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
`ifdef ALU_ISSUE_MUL_EN
    , ST_MUL = 2'd3
`endif
  } st_t;

  st_t         st, st_n;
  logic        rdy;
  dec_t        dec;
  logic [4:0]  fs_q;
  logic        c0_q, sf_q, ill_q;
  logic [63:0] a_q, b_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [63:0] rsp_data_q;
  logic [3:0]  flags_q;
  logic        acc_hs, rsp_hs;

  alu_op_decode u_dec (
    .op  (req_op),
    .dec (dec)
  );

  assign acc_hs    = req_valid && rdy;
  assign rsp_hs    = rsp_valid_q && rsp_ready;
  assign req_ready = rdy;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign flags     = flags_q;

`ifdef ALU_ISSUE_MUL_EN
  logic [63:0] acc, mcand, mplier;
  logic [5:0]  cnt;
  logic        mul_done;

  // last iteration: 64th pass, or nothing left to add
  assign mul_done = (cnt == 6'd63) ||
                    (MUL_EARLY_EXIT &&
                     (mplier[63:1] == '0));

  // shift-add multiply registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (acc_hs) begin
      acc    <= '0;
      mcand  <= req_a;
      mplier <= req_b;
      cnt    <= '0;
    end else if (st == ST_MUL) begin
      acc    <= alu_out;
      mcand  <= {mcand[62:0], 1'b0};
      mplier <= {1'b0, mplier[63:1]};
      cnt    <= cnt + 6'd1;
    end
  end
`endif

  // state register; ready is registered so it stays low in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= ST_IDLE;
      rdy <= 1'b0;
    end else begin
      st  <= st_n;
      rdy <= (st_n == ST_IDLE);
    end
  end

  // next-state logic
  always_comb begin
    st_n = st;
    unique case (st)
      ST_IDLE:
        if (acc_hs) begin
`ifdef ALU_ISSUE_MUL_EN
          st_n = dec.is_mul ? ST_MUL : ST_EXEC;
`else
          st_n = ST_EXEC;
`endif
        end
      ST_EXEC:
        st_n = ST_RESP;
`ifdef ALU_ISSUE_MUL_EN
      ST_MUL:
        if (mul_done) st_n = ST_RESP;
`endif
      ST_RESP:
        if (rsp_hs) st_n = ST_IDLE;
      default:
        st_n = ST_IDLE;
    endcase
  end

  // ALU drive: quiet unless a legal op or MUL step is executing
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fs = FS_AND;
    alu_c0 = 1'b0;
    if ((st == ST_EXEC) && !ill_q) begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_fs = fs_q;
      alu_c0 = c0_q;
    end
`ifdef ALU_ISSUE_MUL_EN
    if (st == ST_MUL) begin
      alu_a  = acc;
      alu_b  = mplier[0] ? mcand : '0;
      alu_fs = FS_ADD;
    end
`endif
  end

  // request capture, response and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_q        <= FS_AND;
      c0_q        <= 1'b0;
      sf_q        <= 1'b0;
      ill_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      flags_q     <= '0;
    end else begin
      if (acc_hs) begin
        fs_q  <= dec.fs;
        c0_q  <= dec.c0;
        sf_q  <= dec.sets_flags;
        ill_q <= dec.illegal;
        a_q   <= req_a;
        b_q   <= req_b;
      end
      if (st == ST_EXEC) begin
        rsp_data_q <= ill_q ? '0 : alu_out;
        rsp_err_q  <= ill_q;
        if (sf_q) flags_q <= alu_status;
      end
`ifdef ALU_ISSUE_MUL_EN
      if ((st == ST_MUL) && mul_done) begin
        rsp_data_q <= alu_out;
        rsp_err_q  <= 1'b0;
      end
`endif
      if (rsp_hs)
        rsp_valid_q <= 1'b0;
      else if (st == ST_RESP)
        rsp_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench with a behavioural ALU model.
// Covers both builds of ALU_ISSUE_MUL_EN.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  flags;
  logic [63:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_fs;
  logic        alu_c0;
  logic [3:0]  alu_status;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .flags      (flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fs     (alu_fs),
    .alu_c0     (alu_c0),
    .alu_out    (alu_out),
    .alu_status (alu_status)
  );

  // behavioural 64-bit ALU
  logic [63:0] bb, m_out;
  logic [64:0] sum;
  logic        m_c, m_v;

  always_comb begin
    bb    = alu_fs[0] ? ~alu_b : alu_b;
    sum   = {1'b0, alu_a} + {1'b0, bb} + {64'd0, alu_c0};
    m_out = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_fs)
      5'b00000: m_out = alu_a & alu_b;
      5'b00100: m_out = alu_a | alu_b;
      5'b01000, 5'b01001: begin
        m_out = sum[63:0];
        m_c   = sum[64];
        m_v   = (alu_a[63] == bb[63]) &&
                (sum[63] != alu_a[63]);
      end
      5'b01100: m_out = alu_a ^ alu_b;
      5'b10000: m_out = alu_a << alu_b[5:0];
      5'b10100: m_out = alu_a >> alu_b[5:0];
      default:  m_out = '0;
    endcase
  end

  assign alu_out    = m_out;
  assign alu_status = {m_v, m_c, m_out[63], m_out == 64'd0};

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic [3:0]  f;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [3:0]  fexp = '0;
  localparam int LIM = 200;

  function automatic logic [63:0] ref_data(
    input logic [3:0] op, input logic [63:0] a, b);
    case (op)
      4'd0, 4'd7: return a & b;
      4'd1:       return a | b;
      4'd2, 4'd8: return a + b;
      4'd3, 4'd9: return a - b;
      4'd4:       return a ^ b;
      4'd5:       return a << b[5:0];
      4'd6:       return a >> b[5:0];
`ifdef ALU_ISSUE_MUL_EN
      4'd10:      return a * b;
`endif
      default:    return '0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [3:0] op);
`ifdef ALU_ISSUE_MUL_EN
    return op > 4'd10;
`else
    return op >= 4'd10;
`endif
  endfunction

  function automatic int ref_lat(
    input logic [3:0] op, input logic [63:0] b);
`ifdef ALU_ISSUE_MUL_EN
    if (op == 4'd10) begin
      for (int i = 63; i >= 0; i--)
        if (b[i]) return i + 2;
      return 2;
    end
`endif
    return 2;
  endfunction

  // issue one request and check the response it produces
  task automatic send(input logic [3:0] op,
                      input logic [63:0] a, b,
                      input logic [3:0] ef,
                      input string nm);
    exp_t x;
    int   lat;
    bit   busy_bad, ill_bad;
    x.d = ref_data(op, a, b);
    x.e = ref_err(op);
    x.f = ef;
    x.lat = ref_lat(op, b);
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back(x);
    lat = 0;
    busy_bad = 1'b0;
    ill_bad = 1'b0;
    while (rsp_valid !== 1'b1 && lat < LIM) begin
      if (req_ready !== 1'b0) busy_bad = 1'b1;
      if (x.e && ((alu_a | alu_b) !== 64'd0))
        ill_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    x = sb.pop_front();
    n_chk++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: no rsp in %0d", nm, LIM);
    end
    n_chk++;
    if (lat != x.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d",
               nm, lat, x.lat);
    end
    n_chk++;
    if (rsp_data !== x.d) begin
      n_fail++;
      $display("FAIL %s data: got %h want %h",
               nm, rsp_data, x.d);
    end
    n_chk++;
    if (rsp_err !== x.e) begin
      n_fail++;
      $display("FAIL %s err: got %b want %b",
               nm, rsp_err, x.e);
    end
    n_chk++;
    if (flags !== x.f) begin
      n_fail++;
      $display("FAIL %s flags: got %b want %b",
               nm, flags, x.f);
    end
    n_chk++;
    if (busy_bad || ill_bad) begin
      n_fail++;
      $display("FAIL %s busy: ready_hi %b alu_nz %b want 0 0",
               nm, busy_bad, ill_bad);
    end
  endtask

  // take the response and check the block returns to idle
  task automatic complete(input string nm);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
        alu_a !== 64'd0 || alu_b !== 64'd0) begin
      n_fail++;
      $display("FAIL %s done: valid %b ready %b a %h b %h want 0 1 0 0",
               nm, rsp_valid, req_ready, alu_a, alu_b);
    end
  endtask

  task automatic run(input logic [3:0] op,
                     input logic [63:0] a, b,
                     input logic [3:0] ef,
                     input string nm);
    send(op, a, b, ef, nm);
    complete(nm);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_data !== 64'd0 ||
        flags !== 4'd0) begin
      n_fail++;
      $display("FAIL reset outs: rdy %b v %b e %b d %h f %b want 0",
               req_ready, rsp_valid, rsp_err, rsp_data, flags);
    end
    n_chk++;
    if (alu_a !== 64'd0 || alu_b !== 64'd0 ||
        alu_fs !== 5'd0 || alu_c0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset alu: a %h b %h fs %b c0 %b want 0",
               alu_a, alu_b, alu_fs, alu_c0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset release: ready %b want 1", req_ready);
    end
  endtask

  task automatic test_subs();
    fexp = 4'b0101;
    run(OP_SUBS, 64'd5, 64'd5, fexp, "subs");
  endtask

  task automatic test_add_wrap();
    run(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, fexp, "add_wrap");
  endtask

  task automatic test_ops();
    run(OP_ORR, 64'hF0F0, 64'h0F0F, fexp, "orr");
    run(OP_EOR, 64'hFF00, 64'h0FF0, fexp, "eor");
    run(OP_LSL, 64'd1, 64'd4, fexp, "lsl");
    run(OP_LSR, 64'h8000_0000_0000_0000, 64'd63, fexp, "lsr");
    run(OP_SUB, 64'd3, 64'd5, fexp, "sub");
    run(OP_AND, 64'hFFFF, 64'h0FF0, fexp, "and");
    fexp = 4'b0001;
    run(OP_ANDS, 64'hF0, 64'h0F, fexp, "ands");
    fexp = 4'b1010;
    run(OP_ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, fexp, "adds");
  endtask

  task automatic test_mul();
    run(OP_MUL, 64'd7, 64'd6, fexp, "mul_7x6");
    run(OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000, fexp, "mul_wrap");
    run(OP_MUL, 64'd5, 64'd0, fexp, "mul_b0");
  endtask

  task automatic test_hold();
    send(4'd13, 64'h1234, 64'h5678, fexp, "ill13");
    req_valid = 1'b1;
    req_op = OP_ADD;
    req_a = 64'd1;
    req_b = 64'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
          rsp_data !== 64'd0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d: v %b e %b d %h rdy %b want 1 1 0 0",
                 i, rsp_valid, rsp_err, rsp_data, req_ready);
      end
    end
    req_valid = 1'b0;
    complete("ill13");
  endtask

  task automatic test_abort();
    bit seen;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_op = OP_MUL;
    req_a = 64'd3;
    req_b = 64'h8000_0000_0000_0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (rsp_valid !== 1'b0 || flags !== 4'd0 ||
        req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: v %b f %b rdy %b want 0 0000 0",
               rsp_valid, flags, req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort release: ready %b want 1", req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort stale: rsp_valid seen 1 want 0");
    end
    fexp = 4'b0000;
    run(OP_ADD, 64'd2, 64'd3, fexp, "post_abort");
  endtask

  initial begin
    test_reset();
    test_subs();
    test_add_wrap();
    test_ops();
    test_mul();
    test_hold();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
